// File: rtl/board_reader.sv
// Scans a 9x9 board snapshot cell by cell and emits each cell over a valid/ready stream.
// Optionally skips zero-valued cells; counts nonzero cells that were transferred.
module board_reader #(
   parameter bit SKIP_EMPTY = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [323:0] board,
   input  logic [80:0]  board_blank,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   out_row,
   output logic [3:0]   out_col,
   output logic [3:0]   out_data,
   output logic         out_blank,
   output logic         busy,
   output logic         done,
   output logic [6:0]   filled_count
);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e         state_q, state_d;
   // Snapshot is kept pre-shifted so its low nibble/bit is always the next cell to present.
   logic [323:0]   snap_board_q, snap_board_d;
   logic [80:0]    snap_blank_q, snap_blank_d;
   logic           out_valid_q, out_valid_d;
   logic [3:0]     out_row_q, out_row_d;
   logic [3:0]     out_col_q, out_col_d;
   logic [3:0]     out_data_q, out_data_d;
   logic           out_blank_q, out_blank_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [6:0]     filled_q, filled_d;

   logic           advance;
   logic           last_cell;
   logic [3:0]     row_nxt, col_nxt;

   always_comb begin
      state_d      = state_q;
      snap_board_d = snap_board_q;
      snap_blank_d = snap_blank_q;
      out_valid_d  = out_valid_q;
      out_row_d    = out_row_q;
      out_col_d    = out_col_q;
      out_data_d   = out_data_q;
      out_blank_d  = out_blank_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      filled_d     = filled_q;
      advance      = 1'b0;

      last_cell = (out_row_q == 4'd8) && (out_col_q == 4'd8);
      if (out_col_q == 4'd8) begin
         col_nxt = 4'd0;
         row_nxt = out_row_q + 4'd1;
      end else begin
         col_nxt = out_col_q + 4'd1;
         row_nxt = out_row_q;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d      = StScan;
               snap_board_d = {4'd0, board[323:4]};
               snap_blank_d = {1'b0, board_blank[80:1]};
               out_row_d    = 4'd0;
               out_col_d    = 4'd0;
               out_data_d   = board[3:0];
               out_blank_d  = board_blank[0];
               out_valid_d  = !SKIP_EMPTY || (board[3:0] != 4'd0);
               filled_d     = 7'd0;
               busy_d       = 1'b1;
            end
         end
         StScan: begin
            if (out_valid_q) begin
               if (out_ready) begin
                  advance = 1'b1;
                  if (out_data_q != 4'd0) begin
                     filled_d = filled_q + 7'd1;
                  end
               end
            end else begin
               // Not presented means the cell was empty and is being skipped.
               advance = 1'b1;
            end

            if (advance) begin
               if (last_cell) begin
                  state_d     = StDone;
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  out_row_d    = row_nxt;
                  out_col_d    = col_nxt;
                  out_data_d   = snap_board_q[3:0];
                  out_blank_d  = snap_blank_q[0];
                  out_valid_d  = !SKIP_EMPTY || (snap_board_q[3:0] != 4'd0);
                  snap_board_d = {4'd0, snap_board_q[323:4]};
                  snap_blank_d = {1'b0, snap_blank_q[80:1]};
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         snap_board_q <= '0;
         snap_blank_q <= '0;
         out_valid_q  <= 1'b0;
         out_row_q    <= 4'd0;
         out_col_q    <= 4'd0;
         out_data_q   <= 4'd0;
         out_blank_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         filled_q     <= 7'd0;
      end else begin
         state_q      <= state_d;
         snap_board_q <= snap_board_d;
         snap_blank_q <= snap_blank_d;
         out_valid_q  <= out_valid_d;
         out_row_q    <= out_row_d;
         out_col_q    <= out_col_d;
         out_data_q   <= out_data_d;
         out_blank_q  <= out_blank_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         filled_q     <= filled_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_row      = out_row_q;
   assign out_col      = out_col_q;
   assign out_data     = out_data_q;
   assign out_blank    = out_blank_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign filled_count = filled_q;

endmodule

// File: tb/tb_board_reader.sv
// Scoreboard bench for board_reader: dut_a without skipping, dut_b with SKIP_EMPTY=1.
module tb_board_reader;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start_a = 1'b0;
   logic         start_b = 1'b0;
   logic         out_ready = 1'b1;
   logic [323:0] board = '0;
   logic [80:0]  board_blank = '0;

   logic       out_valid_a, out_blank_a, busy_a, done_a;
   logic [3:0] out_row_a, out_col_a, out_data_a;
   logic [6:0] filled_count_a;
   logic       out_valid_b, out_blank_b, busy_b, done_b;
   logic [3:0] out_row_b, out_col_b, out_data_b;
   logic [6:0] filled_count_b;

   always #5 clk = ~clk;

   board_reader #(.SKIP_EMPTY(1'b0)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .board(board), .board_blank(board_blank),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_row(out_row_a), .out_col(out_col_a),
      .out_data(out_data_a), .out_blank(out_blank_a), .busy(busy_a), .done(done_a),
      .filled_count(filled_count_a)
   );

   board_reader #(.SKIP_EMPTY(1'b1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .board(board), .board_blank(board_blank),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_row(out_row_b), .out_col(out_col_b),
      .out_data(out_data_b), .out_blank(out_blank_b), .busy(busy_b), .done(done_b),
      .filled_count(filled_count_b)
   );

   typedef struct packed {
      logic [3:0] row;
      logic [3:0] col;
      logic [3:0] data;
      logic       blank;
   } cell_t;

   cell_t exp_a[$];
   cell_t exp_b[$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic push_exp(input bit which, input int r, input int c, input int d, input bit bl);
      cell_t e;
      e = {4'(r), 4'(c), 4'(d), bl};
      if (which) exp_b.push_back(e);
      else exp_a.push_back(e);
   endtask

   task automatic fill_const(input logic [3:0] v);
      for (int i = 0; i < 81; i++) board[i*4 +: 4] = v;
   endtask

   task automatic pulse_start(input bit which);
      if (which) start_b = 1'b1;
      else start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input bit which, input int budget, output int cyc, output int vcyc);
      cyc  = 0;
      vcyc = 0;
      while (!(which ? done_b : done_a) && cyc < budget) begin
         if (which ? out_valid_b : out_valid_a) vcyc++;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= budget) begin
         checks++;
         errors++;
         $display("FAIL wait_done_timeout: dut %0d got no done expected done within %0d", which,
                  budget);
      end
   endtask

   task automatic wait_cell_a(input int r, input int c, input int budget);
      int n;
      n = 0;
      while (!(out_valid_a && out_row_a == 4'(r) && out_col_a == 4'(c)) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL wait_cell_timeout: got no cell (%0d,%0d) expected it within %0d", r, c,
                  budget);
      end
   endtask

   // Monitor: a transfer happens on the next rising edge when valid and ready are both high.
   always @(negedge clk) begin
      cell_t got, e;
      if (out_valid_a && out_ready) begin
         got = {out_row_a, out_col_a, out_data_a, out_blank_a};
         checks++;
         if (exp_a.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected_cell: got r%0d c%0d d%0d b%0d expected none", got.row,
                     got.col, got.data, got.blank);
         end else begin
            e = exp_a.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL a_cell: got r%0d c%0d d%0d b%0d expected r%0d c%0d d%0d b%0d",
                        got.row, got.col, got.data, got.blank, e.row, e.col, e.data, e.blank);
            end
         end
      end
      if (out_valid_b && out_ready) begin
         got = {out_row_b, out_col_b, out_data_b, out_blank_b};
         checks++;
         if (exp_b.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected_cell: got r%0d c%0d d%0d b%0d expected none", got.row,
                     got.col, got.data, got.blank);
         end else begin
            e = exp_b.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL b_cell: got r%0d c%0d d%0d b%0d expected r%0d c%0d d%0d b%0d",
                        got.row, got.col, got.data, got.blank, e.row, e.col, e.data, e.blank);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      int cyc, vcyc;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid_a", out_valid_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_fields_a", {out_row_a, out_col_a, out_data_a, out_blank_a}, 0);
      chk("rst_filled_a", filled_count_a, 0);
      chk("rst_valid_busy_b", {out_valid_b, busy_b, done_b}, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_busy_a", busy_a, 0);

      // All cells 5, full-rate streaming
      fill_const(4'd5);
      board_blank = '0;
      out_ready = 1'b1;
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++) push_exp(0, r, c, 5, 0);
      pulse_start(0);
      chk("t1_first_valid", out_valid_a, 1);
      chk("t1_busy", busy_a, 1);
      wait_done(0, 200, cyc, vcyc);
      chk("t1_cycles", cyc, 81);
      chk("t1_valid_cycles", vcyc, 81);
      chk("t1_done", done_a, 1);
      chk("t1_busy_in_done", busy_a, 1);
      chk("t1_valid_in_done", out_valid_a, 0);
      chk("t1_filled", filled_count_a, 81);
      @(posedge clk);
      #1;
      chk("t1_done_pulse", done_a, 0);
      chk("t1_idle", busy_a, 0);
      chk("t1_filled_hold", filled_count_a, 81);

      // Pattern board, one blank flag, backpressure, board change and start mid-scan
      for (int i = 0; i < 81; i++) board[i*4 +: 4] = 4'(i % 16);
      board_blank = '0;
      board_blank[40] = 1'b1;
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++) push_exp(0, r, c, (r * 9 + c) % 16, (r == 4 && c == 4));
      pulse_start(0);
      fill_const(4'hf);
      board_blank = '1;
      wait_cell_a(2, 8, 200);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("t2_hold_valid", out_valid_a, 1);
         chk("t2_hold_pos", {out_row_a, out_col_a}, {4'd2, 4'd8});
         chk("t2_hold_data", {out_data_a, out_blank_a}, {4'd10, 1'b0});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t2_after_stall", {out_valid_a, out_row_a, out_col_a}, {1'b1, 4'd3, 4'd0});
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      wait_done(0, 200, cyc, vcyc);
      chk("t2_filled", filled_count_a, 75);
      @(posedge clk);
      #1;

      // Skip mode with three nonzero cells
      board = '0;
      board_blank = '0;
      board[3:0] = 4'd1;
      board[40*4 +: 4] = 4'd9;
      board[80*4 +: 4] = 4'd3;
      push_exp(1, 0, 0, 1, 0);
      push_exp(1, 4, 4, 9, 0);
      push_exp(1, 8, 8, 3, 0);
      pulse_start(1);
      wait_done(1, 200, cyc, vcyc);
      chk("t3_cycles", cyc, 81);
      chk("t3_valid_cycles", vcyc, 3);
      chk("t3_filled", filled_count_b, 3);
      chk("t3_sb_empty", exp_b.size(), 0);

      // Start during DONE is dropped, accepted in the first idle cycle; all-zero board follows
      board = '0;
      start_b = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_start_in_done_ignored", busy_b, 0);
      @(posedge clk);
      #1;
      chk("t4_start_after_done", busy_b, 1);
      start_b = 1'b0;
      wait_done(1, 200, cyc, vcyc);
      chk("t4_zero_cycles", cyc, 81);
      chk("t4_zero_valid_cycles", vcyc, 0);
      chk("t4_zero_filled", filled_count_b, 0);
      @(posedge clk);
      #1;

      // Reset mid-scan at (5,3), then a fresh scan from (0,0)
      fill_const(4'd6);
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++) push_exp(0, r, c, 6, 0);
      pulse_start(0);
      wait_cell_a(5, 3, 200);
      reset = 1'b1;
      #1;
      chk("t5_rst_valid_busy_done", {out_valid_a, busy_a, done_a}, 0);
      chk("t5_rst_fields", {out_row_a, out_col_a, out_data_a, out_blank_a}, 0);
      chk("t5_rst_filled", filled_count_a, 0);
      exp_a.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_resume", {busy_a, out_valid_a}, 0);
      fill_const(4'd7);
      for (int r = 0; r < 9; r++)
         for (int c = 0; c < 9; c++) push_exp(0, r, c, 7, 0);
      pulse_start(0);
      chk("t5_restart_pos", {out_valid_a, out_row_a, out_col_a}, {1'b1, 4'd0, 4'd0});
      wait_done(0, 200, cyc, vcyc);
      chk("t5_cycles", cyc, 81);
      chk("t5_filled", filled_count_a, 81);
      @(posedge clk);
      #1;

      chk("sb_a_empty", exp_a.size(), 0);
      chk("sb_b_empty", exp_b.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/board_reader.md
BOARD_READER -- requirements
Module: board_reader

Interface
REQ-001 Parameter: SKIP_EMPTY, default 0; when 1, cells whose 4-bit value is 0 are not emitted.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a scan; sampled only in IDLE.
REQ-005 board  input  324  cell values; cell (r,c) occupies bits (r*9+c)*4+3 down to (r*9+c)*4.
REQ-006 board_blank  input  81  editable-cell flags; bit r*9+c belongs to cell (r,c).
REQ-007 out_valid  output  1  emitted cell fields are valid.
REQ-008 out_ready  input  1  consumer accepts the current cell.
REQ-009 out_row  output  4  row of the emitted cell, 0..8.
REQ-010 out_col  output  4  column of the emitted cell, 0..8.
REQ-011 out_data  output  4  value of the emitted cell.
REQ-012 out_blank  output  1  board_blank bit of the emitted cell.
REQ-013 busy  output  1  a scan is in progress.
REQ-014 done  output  1  one-cycle pulse at the end of a scan.
REQ-015 filled_count  output  7  number of cells with nonzero value in the last scan, 0..81.

Function
REQ-016 States: IDLE, SCAN, DONE. All outputs are registered.
REQ-017 IDLE, start=1 -> on that edge: snapshot board and board_blank into internal registers; index=(0,0); filled_count=0; go to SCAN.
REQ-018 busy=1 in SCAN and DONE; busy=0 in IDLE.
REQ-019 After start, all cell fields come only from the snapshot; changes on board or board_blank during the scan have no effect.
REQ-020 SCAN, current cell emitted -> out_valid=1 and out_row/out_col/out_data/out_blank show the current cell.
REQ-021 With SKIP_EMPTY=0, the first out_valid appears in the cycle after start is sampled.
REQ-022 Handshake: a cell transfers on a rising edge where out_valid=1 and out_ready=1.
REQ-023 While out_valid=1 and out_ready=0, out_valid and all cell fields hold stable.
REQ-024 out_valid never drops without a transfer, except on reset.
REQ-025 On each transfer:
- filled_count increments if out_data != 0.
- index advances: col+1; at col==8, col wraps to 0 and row+1.
REQ-026 Back-to-back: with out_ready held at 1, one cell transfers per cycle.
REQ-027 SKIP_EMPTY=1, current snapshot value 0 -> out_valid=0 for that cell; index advances one cell per cycle; filled_count unchanged.
REQ-028 Completion trigger: index advances past (8,8), whether by transfer or by skip.
REQ-029 On completion: go to DONE; out_valid=0 in the following cycle.
REQ-030 DONE: done=1 for exactly one cycle, then IDLE; done=0 in all other cycles.
REQ-031 filled_count holds its final value from DONE until the next accepted start.
REQ-032 start is ignored while busy=1; it is never queued.
REQ-033 start in the DONE cycle is ignored.
REQ-034 start is accepted in the first IDLE cycle after DONE.
REQ-035 SKIP_EMPTY=1 with an all-zero snapshot -> no transfers, 81 skip cycles, DONE, filled_count=0.
REQ-036 out_ready is ignored whenever out_valid=0.
REQ-037 Index arithmetic: row and col are 4-bit; values 9..15 never occur.

Reset
REQ-038 reset=1 forces IDLE immediately, asynchronously, including mid-scan. It also forces:
- out_valid=0, busy=0, done=0;
- out_row=out_col=out_data=0, out_blank=0;
- filled_count=0;
- snapshot registers cleared.
REQ-039 After reset deasserts, the block waits in IDLE for start; no partial scan resumes.

Verification
REQ-040 SKIP_EMPTY=0, board all cells=5, blank=0, start, out_ready=1 -> 81 transfers in 81 consecutive cycles in order (0,0),(0,1)..(8,8), all data 5; done one cycle later; filled_count=81.
REQ-041 Backpressure: out_ready=0 for 3 cycles at cell (2,8) -> fields (2,8) held stable 3 cycles; next transfer is (3,0).
REQ-042 SKIP_EMPTY=1, only (0,0)=1, (4,4)=9, (8,8)=3 nonzero -> exactly 3 transfers in that order; done after the (8,8) transfer; filled_count=3.
REQ-043 Snapshot: board changed after start -> emitted values match the board at start; a start pulse mid-scan does not restart the scan.
REQ-044 Reset asserted while at cell (5,3) with out_valid=1 -> same cycle, all outputs zero and busy=0; a new start scans from (0,0).
REQ-045 Blank flags: board_blank with only bit 40 set -> out_blank=1 only on cell (4,4).
